// File: rtl/video_pkg.sv
// Shared pixel types and defaults for the capture-to-DVI video path.
package video_pkg;

  localparam int PIXEL_W = 24;
  localparam int ADDR_W  = 20;

  // {R,G,B}, 8 bits per component.
  typedef logic [PIXEL_W-1:0] pixel_t;

  // Colour emitted for raster positions that have no backing storage.
  localparam pixel_t FILL_COLOR = 24'hFFFFFF;

  // One beat on the DVI side: the pixel and its start-of-frame marker.
  typedef struct packed {
    logic   sof;
    pixel_t pixel;
  } video_beat_t;

  // Tag that travels alongside a read while the BRAM is producing its data.
  typedef struct packed {
    logic sof;
    logic inbuf;
  } read_tag_t;

endpackage

// File: rtl/pixel_skid_buffer.sv
// Two-entry ready/valid FIFO that absorbs the BRAM read latency.
// The occupancy output lets the upstream issue stage run on credits.
module pixel_skid_buffer #(
  parameter int DATA_W = 25
) (
  input  logic              cpu_clk_g,
  input  logic              rst,          // asynchronous, active-low
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] entry [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              do_push;
  logic              do_pop;

  // Handshake decode and head-of-queue presentation.
  // NOTE: every signal written here is assigned on every pass, so no latch is inferred.
  always_comb begin
    push_ready = (count != 2'd2);
    pop_valid  = (count != 2'd0);
    do_push    = push_valid && push_ready;
    do_pop     = pop_valid && pop_ready;
    pop_data   = entry[rd_ptr];
    occupancy  = count;
  end

  // Storage, pointers and fill level; entries clear so the head reads 0 in reset.
  // NOTE: state updates use non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge cpu_clk_g or negedge rst) begin
    if (!rst) begin
      entry[0] <= '0;
      entry[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (do_push) begin
        entry[wr_ptr] <= push_data;
        wr_ptr        <= !wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= !rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_buffer_streamer.sv
// Frame store fed by the capture FIFO and a continuous raster streamer to DVI.
// Read path: issue (raster counter) -> BRAM (1 cycle) -> 2-entry skid buffer.
module frame_buffer_streamer
  import video_pkg::*;
#(
  parameter int     Width      = 1024,
  parameter int     Height     = 768,
  parameter int     BufferSize = 24000,
  parameter int     AddrWidth  = ADDR_W,
  parameter pixel_t FillColor  = FILL_COLOR
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 InValid,
  input  logic [AddrWidth-1:0] InAddr,
  input  logic [PIXEL_W-1:0]   InPixel,
  output logic [PIXEL_W-1:0]   Video,
  output logic                 VideoValid,
  input  logic                 VideoReady,
  output logic                 VideoSOF,
  output logic [15:0]          DropCount
);

  localparam int MEM_AW = (BufferSize > 1) ? $clog2(BufferSize) : 1;
  localparam logic [AddrWidth-1:0] BUF_LIMIT = AddrWidth'(BufferSize);
  localparam logic [AddrWidth-1:0] LAST_POS  = AddrWidth'(Width * Height - 1);

  pixel_t              mem [BufferSize];
  pixel_t              mem_q;

  logic                wr_en;
  logic                drop;

  logic [AddrWidth-1:0] p;
  logic                rd_vld;
  read_tag_t           rd_tag;
  logic                issue;
  logic [MEM_AW-1:0]   rd_addr;
  logic [2:0]          credit_used;

  logic [1:0]          skid_occ;
  logic                skid_space;
  logic                skid_pop;
  video_beat_t         push_beat;
  video_beat_t         head_beat;

  // Write-port decode: in-range writes land in memory, the rest are counted.
  always_comb begin
    wr_en = InValid && (InAddr < BUF_LIMIT);
    drop  = InValid && !(InAddr < BUF_LIMIT);
  end

  // Issue credit: reads in flight plus beats that stay in the skid after this
  // cycle's pop. Counting the pop keeps 1 pixel/cycle with a 2-entry skid.
  always_comb begin
    skid_pop    = VideoValid && VideoReady;
    credit_used = {2'b00, rd_vld} + {1'b0, skid_occ} - {2'b00, skid_pop};
    issue       = (credit_used < 3'd2);
    rd_addr     = (p < BUF_LIMIT) ? p[MEM_AW-1:0] : '0;
  end

  // Raster counter and the tag that rides with each read through the BRAM.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      p      <= '0;
      rd_vld <= 1'b0;
      rd_tag <= '0;
    end else begin
      rd_vld <= issue;
      if (issue) begin
        rd_tag.sof   <= (p == '0);
        rd_tag.inbuf <= (p < BUF_LIMIT);
        p            <= (p == LAST_POS) ? '0 : p + 1'b1;
      end
    end
  end

  // Simple dual-port BRAM; a same-address read and write returns the old word.
  // NOTE: the frame store has no reset; its contents survive Reset_n and stay BRAM-mappable.
  always_ff @(posedge Clock) begin
    if (wr_en) begin
      mem[InAddr[MEM_AW-1:0]] <= InPixel;
    end
    if (issue) begin
      mem_q <= mem[rd_addr];
    end
  end

  // Substitute the fill colour for positions beyond the stored region.
  always_comb begin
    push_beat.sof   = rd_tag.sof;
    push_beat.pixel = rd_tag.inbuf ? mem_q : FillColor;
  end

  // Discarded-write counter, saturating at all ones.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      DropCount <= 16'd0;
    end else if (drop && (DropCount != 16'hFFFF)) begin
      DropCount <= DropCount + 16'd1;
    end
  end

  pixel_skid_buffer #(
    .DATA_W($bits(video_beat_t))
  ) u_skid (
    .cpu_clk_g  (Clock),
    .rst        (Reset_n),
    .push_valid (rd_vld && skid_space),
    .push_ready (skid_space),
    .push_data  (push_beat),
    .pop_valid  (VideoValid),
    .pop_ready  (VideoReady),
    .pop_data   (head_beat),
    .occupancy  (skid_occ)
  );

  assign Video    = head_beat.pixel;
  assign VideoSOF = head_beat.sof;

endmodule

// File: tb/tb_frame_buffer_streamer.sv
// Directed bench for frame_buffer_streamer on a reduced 16x12 raster with a
// 100-word store. A raster model checks every accepted beat; literal
// expectations pin first-pixel latency, read-first behaviour and DropCount.
`timescale 1ns/1ps
module tb_frame_buffer_streamer;

  localparam int          W     = 16;
  localparam int          H     = 12;
  localparam int          BUF   = 100;
  localparam int          AW    = 20;
  localparam int          TOTAL = W * H;
  localparam logic [23:0] FILL  = 24'hFFFFFF;

  logic          Clock = 1'b0;
  logic          Reset_n;
  logic          InValid;
  logic [AW-1:0] InAddr;
  logic [23:0]   InPixel;
  logic [23:0]   Video;
  logic          VideoValid;
  logic          VideoReady;
  logic          VideoSOF;
  logic [15:0]   DropCount;

  int vectors     = 0;
  int miscompares = 0;

  // Bench-side picture of what the frame store should hold.
  logic [23:0] model_mem [BUF];
  logic [23:0] first4 [4] = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};

  bit check_en   = 1'b0;
  int ready_mode = 0;     // 0: always ready, 1: pattern 1,0,0,1,0,1, 2: never ready
  int sof_total  = 0;
  int sof_base;

  frame_buffer_streamer #(
    .Width      (W),
    .Height     (H),
    .BufferSize (BUF),
    .AddrWidth  (AW),
    .FillColor  (FILL)
  ) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .InValid    (InValid),
    .InAddr     (InAddr),
    .InPixel    (InPixel),
    .Video      (Video),
    .VideoValid (VideoValid),
    .VideoReady (VideoReady),
    .VideoSOF   (VideoSOF),
    .DropCount  (DropCount)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [23:0] ref_pixel(input int q);
    return (q < BUF) ? model_mem[q] : FILL;
  endfunction

  // Ready generator.
  initial begin : ready_gen
    bit ready_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int phase;
    phase      = 0;
    VideoReady = 1'b1;
    forever begin
      @(posedge Clock);
      #2;
      case (ready_mode)
        0: VideoReady = 1'b1;
        1: begin
          VideoReady = ready_pat[phase];
          phase      = (phase + 1) % 6;
        end
        default: VideoReady = 1'b0;
      endcase
    end
  end

  // Compare process: raster order, SOF, frame length, stall stability, no bubbles.
  initial begin : compare
    int          exp_p        = 0;
    int          hs_since_sof = 0;
    bit          have_sof     = 1'b0;
    bit          prev_stall   = 1'b0;
    bit          armed        = 1'b0;
    logic [23:0] prev_video   = '0;
    logic        prev_sof     = 1'b0;
    forever begin
      @(negedge Clock);
      if (!Reset_n) begin
        exp_p        = 0;
        hs_since_sof = 0;
        have_sof     = 1'b0;
        prev_stall   = 1'b0;
        armed        = 1'b0;
      end else if (check_en) begin
        if (prev_stall) begin
          check("stall_valid", VideoValid, 1);
          check("stall_video", Video, prev_video);
          check("stall_sof", VideoSOF, prev_sof);
        end
        if (ready_mode == 0 && armed) begin
          check("no_bubble", VideoValid, 1);
        end
        if (VideoValid && VideoReady) begin
          check("raster_pixel", Video, ref_pixel(exp_p));
          check("raster_sof", VideoSOF, (exp_p == 0));
          if (exp_p == 0) begin
            sof_total++;
            if (have_sof) check("frame_len", hs_since_sof, TOTAL);
            have_sof     = 1'b1;
            hs_since_sof = 0;
          end
          hs_since_sof++;
          exp_p = (exp_p + 1) % TOTAL;
        end
        armed      = (ready_mode == 0) && (armed || VideoValid);
        prev_stall = VideoValid && !VideoReady;
        prev_video = Video;
        prev_sof   = VideoSOF;
      end
    end
  end

  // Watchdog.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    Reset_n = 1'b0;
    InValid = 1'b0;
    InAddr  = '0;
    InPixel = '0;

    // Reset state.
    repeat (2) tick();
    check("rst_video", Video, 0);
    check("rst_valid", VideoValid, 0);
    check("rst_sof", VideoSOF, 0);
    check("rst_drop", DropCount, 0);

    // Preload the whole store (address BUF-1 is the last accepted one).
    Reset_n = 1'b1;
    for (int i = 0; i < BUF; i++) begin
      model_mem[i] = (i < 4) ? first4[i] : (24'hC00000 | 24'(i));
      InValid = 1'b1;
      InAddr  = AW'(i);
      InPixel = model_mem[i];
      tick();
    end
    InValid = 1'b0;
    tick();
    check("no_drop_in_range", DropCount, 0);

    // Asynchronous reset while streaming; memory contents must survive it.
    @(posedge Clock);
    #3;
    Reset_n = 1'b0;
    #1;
    check("async_rst_valid", VideoValid, 0);
    tick();
    check_en = 1'b1;
    Reset_n  = 1'b1;

    // Ready held high: latency, first pixels, read-first write at p=5, frame wrap.
    sof_base = sof_total;
    for (int e = 1; e <= 400; e++) begin
      @(posedge Clock);
      #1;
      case (e)
        1: check("first_valid_late", VideoValid, 0);
        2: begin
          check("first_valid", VideoValid, 1);
          check("first_sof", VideoSOF, 1);
          check("first_pixel", Video, 24'h010203);
        end
        3: begin
          check("pixel1", Video, 24'h040506);
          check("pixel1_sof", VideoSOF, 0);
        end
        4: check("pixel2", Video, 24'h070809);
        5: begin
          check("pixel3", Video, 24'h0A0B0C);
          InValid = 1'b1;
          InAddr  = AW'(5);
          InPixel = 24'h123456;
        end
        6: InValid = 1'b0;
        7: check("read_first_old", Video, 24'hC00005);
        8: model_mem[5] = 24'h123456;
        194: begin
          check("frame2_sof", VideoSOF, 1);
          check("frame2_pixel0", Video, 24'h010203);
        end
        199: check("write_visible_next_frame", Video, 24'h123456);
        default: ;
      endcase
    end
    check("sof_per_frame", sof_total - sof_base, 3);

    // Backpressure pattern 1,0,0,1,0,1.
    ready_mode = 1;
    repeat (1200) tick();

    // Dropped writes and saturation, while the stream keeps running.
    InValid = 1'b1;
    InPixel = 24'hDEAD00;
    InAddr  = AW'(24000);
    tick();
    check("drop_24000", DropCount, 1);
    InAddr = AW'(30000);
    tick();
    check("drop_30000", DropCount, 2);
    InAddr = AW'(BUF);
    tick();
    check("drop_boundary", DropCount, 3);
    InAddr = AW'(50000);
    repeat (65531) tick();
    check("drop_near_sat", DropCount, 16'hFFFE);
    repeat (5) tick();
    check("drop_saturated", DropCount, 16'hFFFF);
    InValid = 1'b0;

    // One more full frame at full rate: stored contents must be unchanged.
    ready_mode = 0;
    repeat (250) tick();

    // Fill the skid with the sink stalled, then reset mid-line.
    ready_mode = 2;
    repeat (6) tick();
    check("stall_skid_holds", VideoValid, 1);
    @(posedge Clock);
    #3;
    Reset_n = 1'b0;
    #1;
    check("midline_rst_video", Video, 0);
    check("midline_rst_valid", VideoValid, 0);
    check("midline_rst_sof", VideoSOF, 0);
    check("midline_rst_drop", DropCount, 0);
    tick();
    ready_mode = 0;
    Reset_n    = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge Clock);
      #1;
      case (e)
        1: check("restart_valid_late", VideoValid, 0);
        2: begin
          check("restart_valid", VideoValid, 1);
          check("restart_sof", VideoSOF, 1);
          check("restart_pixel", Video, 24'h010203);
        end
        3: check("restart_pixel1", Video, 24'h040506);
        default: ;
      endcase
    end
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
